// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: state encoding,
// default timeout/error values and the wait-counter width helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_HOLD   = 2'd3
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'hFFFF_FFFF;

    // Counter must hold 0..limit; a zero limit still needs one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Saturating wait counter for a granted transfer; expire is high while the
// count sits at LIMIT.
module mem_arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W       = wait_cnt_width(LIMIT);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT_V)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto a shared peripheral bus with round-robin or fixed
// priority, one cycle of arbitration latency and a timeout abort path.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        timeout_pulse,
    output logic [31:0] timeout_addr
);

    arb_state_e  state_q, state_d;
    logic        last_q, last_d;
    logic [31:0] timeout_addr_q, timeout_addr_d;

    logic        granted;
    logic        grant_sel;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;
    logic        wd_expire;
    logic        done;
    logic [31:0] ret_rdata;

    assign granted   = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign grant_sel = (state_q == ST_GRANT1);
    assign g_addr    = grant_sel ? m1_addr  : m0_addr;
    assign g_wdata   = grant_sel ? m1_wdata : m0_wdata;
    assign g_wstrb   = grant_sel ? m1_wstrb : m0_wstrb;

    mem_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (!granted),
        .enable (granted && !s_ready),
        .expire (wd_expire)
    );

    // last_q remembers the most recently served master (1 = m1), so a tie
    // goes to the other one when round-robin is enabled.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        timeout_addr_d = timeout_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = (ROUND_ROBIN && !last_q) ? ST_GRANT1 : ST_GRANT0;
                end else if (m0_valid) begin
                    state_d = ST_GRANT0;
                end else if (m1_valid) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (s_ready) begin
                    state_d = ST_IDLE;
                    last_d  = grant_sel;
                end else if (wd_expire) begin
                    state_d        = ST_HOLD;
                    last_d         = grant_sel;
                    timeout_addr_d = g_addr;
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            last_q         <= 1'b1;
            timeout_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            timeout_addr_q <= timeout_addr_d;
        end
    end

    // Every output is forced low while resetn is asserted, even mid-grant.
    assign s_valid       = resetn && granted;
    assign s_addr        = s_valid ? g_addr  : '0;
    assign s_wdata       = s_valid ? g_wdata : '0;
    assign s_wstrb       = s_valid ? g_wstrb : '0;
    assign done          = s_valid && (s_ready || wd_expire);
    assign ret_rdata     = s_ready ? s_rdata : ERR_RDATA;
    assign m0_ready      = done && !grant_sel;
    assign m1_ready      = done && grant_sel;
    assign m0_rdata      = m0_ready ? ret_rdata : '0;
    assign m1_rdata      = m1_ready ? ret_rdata : '0;
    assign timeout_pulse = s_valid && !s_ready && wd_expire;
    assign timeout_addr  = resetn ? timeout_addr_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios on a round-robin and a
// fixed-priority instance plus a randomized run against a transaction model.
module tb_mem_arbiter;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m_valid [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_ready, m1_ready, s_valid, timeout_pulse;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, timeout_addr;
    logic [3:0]  s_wstrb;

    logic        r0_m0_ready, r0_m1_ready, r0_s_valid, r0_timeout_pulse;
    logic [31:0] r0_m0_rdata, r0_m1_rdata, r0_s_addr, r0_s_wdata, r0_timeout_addr;
    logic [3:0]  r0_s_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .ROUND_ROBIN(1'b1), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m_valid[0]), .m0_ready(m0_ready), .m0_addr(m_addr[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_rdata(m0_rdata),
        .m1_valid(m_valid[1]), .m1_ready(m1_ready), .m1_addr(m_addr[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .timeout_pulse(timeout_pulse), .timeout_addr(timeout_addr)
    );

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .ROUND_ROBIN(1'b0), .ERR_RDATA(ERR)) dut_fixed (
        .clk(clk), .resetn(resetn),
        .m0_valid(m_valid[0]), .m0_ready(r0_m0_ready), .m0_addr(m_addr[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_rdata(r0_m0_rdata),
        .m1_valid(m_valid[1]), .m1_ready(r0_m1_ready), .m1_addr(m_addr[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_rdata(r0_m1_rdata),
        .s_valid(r0_s_valid), .s_ready(s_ready), .s_addr(r0_s_addr), .s_wdata(r0_s_wdata),
        .s_wstrb(r0_s_wstrb), .s_rdata(s_rdata),
        .timeout_pulse(r0_timeout_pulse), .timeout_addr(r0_timeout_addr)
    );

    // Moves to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        s_ready = 1'b0;
        s_rdata = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        resetn = 1'b0;
        m_valid[0] = 1'b1; m_valid[1] = 1'b1;
        m_addr[0] = 32'h1111_0000; m_wdata[0] = 32'h2222_0000; m_wstrb[0] = 4'hF;
        s_ready = 1'b1; s_rdata = 32'h5A5A_5A5A;
        step();
        #1;
        total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_valid got %b want 0", s_valid); end
        total++; if (s_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_s_addr got %h want 0", s_addr); end
        total++; if (s_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_s_wdata got %h want 0", s_wdata); end
        total++; if (s_wstrb !== 4'h0) begin bad++; $display("[TB] FAIL reset_s_wstrb got %h want 0", s_wstrb); end
        total++; if (m0_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_m0_ready got %b want 0", m0_ready); end
        total++; if (m1_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_m1_ready got %b want 0", m1_ready); end
        total++; if (timeout_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulse got %b want 0", timeout_pulse); end
        total++; if (timeout_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_taddr got %h want 0", timeout_addr); end
        do_reset();
        #1;
        total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_s_valid got %b want 0", s_valid); end
        total++; if (timeout_addr !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_taddr got %h want 0", timeout_addr); end
    endtask

    task automatic test_single_read();
        do_reset();
        m_valid[0] = 1'b1; m_addr[0] = 32'h0300_0004; m_wstrb[0] = 4'h0; m_wdata[0] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            s_ready = (c == 3);
            s_rdata = (c == 3) ? 32'h0000_00A5 : 32'h0BAD_0BAD;
            #1;
            total++; if (s_valid !== (c >= 1 && c <= 3)) begin bad++; $display("[TB] FAIL read_s_valid c=%0d got %b", c, s_valid); end
            total++; if (m0_ready !== (c == 3)) begin bad++; $display("[TB] FAIL read_m0_ready c=%0d got %b", c, m0_ready); end
            total++; if (m1_ready !== 1'b0) begin bad++; $display("[TB] FAIL read_m1_ready c=%0d got %b want 0", c, m1_ready); end
            if (c == 1) begin
                total++; if (s_addr !== 32'h0300_0004) begin bad++; $display("[TB] FAIL read_s_addr got %h want 03000004", s_addr); end
            end
            if (c == 3) begin
                total++; if (m0_rdata !== 32'h0000_00A5) begin bad++; $display("[TB] FAIL read_rdata got %h want 000000a5", m0_rdata); end
            end
            step();
            if (c == 3) m_valid[0] = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        do_reset();
        m_valid[0] = 1'b1; m_valid[1] = 1'b1;
        m_addr[0] = 32'h1000_0000; m_addr[1] = 32'h2000_0000;
        s_ready = 1'b1; s_rdata = $urandom;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_addr = (c % 4 == 1) ? m_addr[0] : (c % 4 == 3) ? m_addr[1] : 32'h0;
            total++; if (m0_ready !== (c % 4 == 1)) begin bad++; $display("[TB] FAIL rr_m0_ready c=%0d got %b", c, m0_ready); end
            total++; if (m1_ready !== (c % 4 == 3)) begin bad++; $display("[TB] FAIL rr_m1_ready c=%0d got %b", c, m1_ready); end
            total++; if (s_addr !== exp_addr) begin bad++; $display("[TB] FAIL rr_s_addr c=%0d got %h want %h", c, s_addr, exp_addr); end
            total++; if (r0_m0_ready !== (c % 2 == 1)) begin bad++; $display("[TB] FAIL fixed_m0_ready c=%0d got %b", c, r0_m0_ready); end
            total++; if (r0_m1_ready !== 1'b0) begin bad++; $display("[TB] FAIL fixed_m1_ready c=%0d got %b want 0", c, r0_m1_ready); end
            if (c % 4 == 1) m_addr[0] = m_addr[0] + 32'h4;
            if (c % 4 == 3) m_addr[1] = m_addr[1] + 32'h4;
            step();
        end
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        m_valid[1] = 1'b1; m_addr[1] = 32'h0400_0000; m_wstrb[1] = 4'hF; m_wdata[1] = $urandom;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (timeout_pulse === 1'b1) pulses++;
            if (c >= 1 && c <= 8) begin
                total++; if (s_valid !== 1'b1 || s_wstrb !== 4'hF || s_addr !== 32'h0400_0000) begin
                    bad++; $display("[TB] FAIL to_grant c=%0d got v=%b strb=%h addr=%h", c, s_valid, s_wstrb, s_addr); end
                total++; if (m1_ready !== 1'b0) begin bad++; $display("[TB] FAIL to_early_ready c=%0d got %b want 0", c, m1_ready); end
            end
            if (c == 9) begin
                total++; if (m1_ready !== 1'b1) begin bad++; $display("[TB] FAIL to_m1_ready got %b want 1", m1_ready); end
                total++; if (m1_rdata !== ERR) begin bad++; $display("[TB] FAIL to_rdata got %h want %h", m1_rdata, ERR); end
                total++; if (timeout_pulse !== 1'b1) begin bad++; $display("[TB] FAIL to_pulse got %b want 1", timeout_pulse); end
                total++; if (m0_ready !== 1'b0) begin bad++; $display("[TB] FAIL to_m0_ready got %b want 0", m0_ready); end
            end
            if (c == 10) begin
                total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL to_hold_s_valid got %b want 0", s_valid); end
                total++; if (m1_ready !== 1'b0) begin bad++; $display("[TB] FAIL to_hold_ready got %b want 0", m1_ready); end
                total++; if (timeout_addr !== 32'h0400_0000) begin bad++; $display("[TB] FAIL to_taddr got %h want 04000000", timeout_addr); end
            end
            if (c == 11) begin
                total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL to_idle_s_valid got %b want 0", s_valid); end
            end
            step();
            if (c == 9) begin m_valid[1] = 1'b0; s_ready = 1'b1; end
            if (c == 10) s_ready = 1'b0;
        end
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL to_pulse_count got %0d want 1", pulses); end
    endtask

    task automatic test_ready_at_timeout();
        do_reset();
        m_valid[0] = 1'b1; m_addr[0] = 32'h0500_0010; m_wstrb[0] = 4'h0;
        for (int c = 0; c < 12; c++) begin
            s_ready = (c == 9 || c == 11);
            s_rdata = (c == 9) ? 32'h1234_5678 : 32'hDEAD_BEEF;
            #1;
            total++; if (timeout_pulse !== 1'b0) begin bad++; $display("[TB] FAIL rt_pulse c=%0d got %b want 0", c, timeout_pulse); end
            if (c == 9) begin
                total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
                    bad++; $display("[TB] FAIL rt_complete got rdy=%b rdata=%h want 1/12345678", m0_ready, m0_rdata); end
            end
            if (c == 10) begin
                total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL rt_idle got %b want 0", s_valid); end
            end
            if (c == 11) begin
                total++; if (s_valid !== 1'b1 || m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
                    bad++; $display("[TB] FAIL rt_regrant got v=%b rdy=%b rdata=%h", s_valid, m0_ready, m0_rdata); end
                total++; if (timeout_addr !== 32'h0) begin bad++; $display("[TB] FAIL rt_taddr got %h want 0", timeout_addr); end
            end
            step();
            if (c == 11) m_valid[0] = 1'b0;
        end
        s_ready = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        m_valid[0] = 1'b1; m_addr[0] = 32'h0600_0000; m_wstrb[0] = 4'h3;
        #1;
        total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL mr_c0 got %b want 0", s_valid); end
        step();
        #1;
        total++; if (s_valid !== 1'b1) begin bad++; $display("[TB] FAIL mr_grant got %b want 1", s_valid); end
        step();
        resetn = 1'b0; s_ready = 1'b1; s_rdata = 32'h7777_7777;
        #1;
        total++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m0_rdata !== 32'h0 || s_addr !== 32'h0) begin
            bad++; $display("[TB] FAIL mr_in_reset got v=%b rdy=%b rdata=%h addr=%h", s_valid, m0_ready, m0_rdata, s_addr); end
        step();
        resetn = 1'b1; s_ready = 1'b0;
        #1;
        total++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL mr_after_reset got v=%b rdy=%b want 0/0", s_valid, m0_ready); end
        step();
        s_ready = 1'b1;
        #1;
        total++; if (s_valid !== 1'b1 || s_addr !== 32'h0600_0000 || m0_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL mr_rearb got v=%b addr=%h rdy=%b", s_valid, s_addr, m0_ready); end
        step();
        m_valid[0] = 1'b0; s_ready = 1'b0;
        #1;
        total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL mr_done got %b want 0", s_valid); end
    endtask

    task automatic test_idle_bus();
        do_reset();
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < 2; i++) begin
                m_addr[i] = $urandom; m_wdata[i] = $urandom; m_wstrb[i] = 4'($urandom);
            end
            s_ready = 1'($urandom); s_rdata = $urandom;
            #1;
            total++; if (s_valid !== 1'b0 || s_wstrb !== 4'h0 || s_addr !== 32'h0) begin
                bad++; $display("[TB] FAIL idle c=%0d got v=%b strb=%h addr=%h", c, s_valid, s_wstrb, s_addr); end
            total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL idle_ready c=%0d got %b%b want 00", c, m0_ready, m1_ready); end
            step();
        end
        s_ready = 1'b0;
    endtask

    // Transaction model: owner is -1 (nobody), 0/1 (granted master) or 2 (post-abort gap).
    task automatic test_random();
        int          owner, waited, last, n_owner;
        logic        exp_sv, exp_pulse;
        logic [31:0] exp_addr, exp_wdata, exp_taddr, new_taddr;
        logic [3:0]  exp_wstrb;
        logic        exp_rdy [2];
        logic [31:0] exp_rd  [2];
        do_reset();
        owner = -1; waited = 0; last = 1; exp_taddr = 32'h0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_valid[i] && $urandom_range(0, 2) == 0) begin
                    m_valid[i] = 1'b1; m_addr[i] = $urandom; m_wdata[i] = $urandom; m_wstrb[i] = 4'($urandom);
                end
            end
            s_ready = (c < 300) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 11) == 0);
            s_rdata = $urandom;
            #1;
            exp_sv = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; exp_pulse = 1'b0;
            exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
            n_owner = owner; new_taddr = exp_taddr;
            if (owner == 0 || owner == 1) begin
                exp_sv = 1'b1; exp_addr = m_addr[owner]; exp_wdata = m_wdata[owner]; exp_wstrb = m_wstrb[owner];
                if (s_ready) begin
                    exp_rdy[owner] = 1'b1; exp_rd[owner] = s_rdata; n_owner = -1; last = owner;
                end else if (waited == TO) begin
                    exp_rdy[owner] = 1'b1; exp_rd[owner] = ERR; exp_pulse = 1'b1;
                    new_taddr = m_addr[owner]; n_owner = 2; last = owner;
                end else begin
                    waited++;
                end
            end else if (owner == 2) begin
                n_owner = -1;
            end else if (m_valid[0] || m_valid[1]) begin
                n_owner = (m_valid[0] && m_valid[1]) ? ((last == 0) ? 1 : 0) : (m_valid[0] ? 0 : 1);
                waited = 0;
            end
            total++; if (s_valid !== exp_sv || s_addr !== exp_addr || s_wdata !== exp_wdata || s_wstrb !== exp_wstrb) begin
                bad++; $display("[TB] FAIL rnd_bus c=%0d got v=%b a=%h d=%h s=%h want v=%b a=%h d=%h s=%h",
                                c, s_valid, s_addr, s_wdata, s_wstrb, exp_sv, exp_addr, exp_wdata, exp_wstrb); end
            total++; if (m0_ready !== exp_rdy[0] || m0_rdata !== exp_rd[0]) begin
                bad++; $display("[TB] FAIL rnd_m0 c=%0d got %b/%h want %b/%h", c, m0_ready, m0_rdata, exp_rdy[0], exp_rd[0]); end
            total++; if (m1_ready !== exp_rdy[1] || m1_rdata !== exp_rd[1]) begin
                bad++; $display("[TB] FAIL rnd_m1 c=%0d got %b/%h want %b/%h", c, m1_ready, m1_rdata, exp_rdy[1], exp_rd[1]); end
            total++; if (timeout_pulse !== exp_pulse || timeout_addr !== exp_taddr) begin
                bad++; $display("[TB] FAIL rnd_timeout c=%0d got %b/%h want %b/%h", c, timeout_pulse, timeout_addr, exp_pulse, exp_taddr); end
            for (int i = 0; i < 2; i++) if (exp_rdy[i]) m_valid[i] = 1'b0;
            owner = n_owner;
            exp_taddr = new_taddr;
            step();
        end
        m_valid[0] = 1'b0; m_valid[1] = 1'b0; s_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL sim_time_limit expired got no finish want finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_grant();
        test_idle_bus();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles a granted transfer may wait for s_ready before abort.
REQ-002 Parameter ROUND_ROBIN, default 1: 1 = alternate priority; 0 = m0 always wins.
REQ-003 Parameter ERR_RDATA, default 32'hFFFF_FFFF: read data returned on abort.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 m0_valid / m1_valid  input  1  master request, held high until matching ready.
REQ-007 m0_ready / m1_ready  output  1  single-cycle transfer completion to master.
REQ-008 m0_addr, m0_wdata / m1_addr, m1_wdata  input  32  master address and write data.
REQ-009 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-010 m0_rdata / m1_rdata  output  32  read data, valid only when the matching ready is high.
REQ-011 s_valid  output  1  request to the shared peripheral bus.
REQ-012 s_ready  input  1  OR of slave readies.
REQ-013 s_addr, s_wdata  output  32; s_wstrb  output  4; s_rdata  input  32.
REQ-014 timeout_pulse  output  1  one-cycle abort indication (interrupt source).
REQ-015 timeout_addr  output  32  address of the most recent aborted transfer.

Function
REQ-016 FSM states: IDLE, GRANT0, GRANT1, HOLD.
REQ-017 IDLE: if any m*_valid is high, register the winner and enter GRANTn next cycle; otherwise stay.
REQ-018 Arbitration: single requester wins; both requesting, ROUND_ROBIN=1 grants the master not granted last; ROUND_ROBIN=0 grants m0.
REQ-019 GRANTn: s_valid=1; s_addr/s_wdata/s_wstrb driven combinationally from master n.
REQ-020 Outside GRANTn: s_valid=0, s_wstrb=0, s_addr=0, s_wdata=0.
REQ-021 mn_ready = (state==GRANTn) & s_ready, combinational; mn_rdata = s_rdata in that cycle, else 0.
REQ-022 The non-granted master's ready shall stay 0.
REQ-023 s_ready in GRANTn: complete, update last-granted to n, return to IDLE; arbitration adds exactly one cycle of latency.
REQ-024 Wait counter: cleared on entering GRANTn, incremented each GRANTn cycle without s_ready; saturating width ceil(log2(TIMEOUT_CYCLES+1)).
REQ-025 Counter == TIMEOUT_CYCLES with s_ready low: mn_ready=1, mn_rdata=ERR_RDATA, timeout_pulse=1, latch timeout_addr; next state HOLD.
REQ-026 s_ready and timeout in the same cycle: normal completion wins; no pulse.
REQ-027 HOLD: one cycle with s_valid=0, ignoring s_ready; then IDLE.
REQ-028 HOLD updates last-granted as a normal completion.
REQ-029 A master dropping valid while granted is illegal; behaviour is unspecified beyond FSM recovery via timeout.

Reset
REQ-030 resetn low at a clock edge: state=IDLE, counter=0, last-granted=m1 (m0 wins first tie), timeout_addr=0.
REQ-031 Under reset, all outputs are 0, including mid-transfer; a pending grant is discarded without ready.

Structure
REQ-032 Shared package holds the state encoding, default TIMEOUT_CYCLES and ERR_RDATA.
REQ-033 One sub-module, mem_arb_watchdog (counter + compare, clear/enable inputs, expire output); all else inline.
REQ-034 No combinational path from m*_valid to s_valid; s_ready to m*_ready is the only combinational feed-through besides the grant mux.

Verification
REQ-035 m0 read addr 32'h0300_0004, slave ready 2 cycles after s_valid returning 32'h0000_00A5 -> s_valid rises 1 cycle after m0_valid; m0_ready with rdata 32'h0000_00A5 at cycle 3; m1_ready stays 0.
REQ-036 m0 and m1 both valid from reset, zero-wait slave -> grants m0,m1,m0,m1; each master has one transfer in flight; ROUND_ROBIN=0 -> m0 served back-to-back while valid.
REQ-037 m1 write addr 32'h0400_0000, wstrb 4'hF, s_ready never high, TIMEOUT_CYCLES=8 -> m1_ready and timeout_pulse once after 8 wait cycles, rdata 32'hFFFF_FFFF, timeout_addr=32'h0400_0000, s_valid low during HOLD.
REQ-038 s_ready high exactly in the cycle the counter reaches TIMEOUT_CYCLES -> normal completion with slave rdata, no timeout_pulse.
REQ-039 resetn low for 1 cycle while in GRANT0 -> s_valid, m0_ready 0 next cycle; state IDLE; m0 re-arbitrated after reset release.
REQ-040 Idle bus, no requests -> s_valid=0, s_wstrb=0, s_addr=0 for 100 cycles.
